// File: rtl/din_debounce_pkg.sv
// Shared definitions for the din_debounce_edge input debouncer.
// Provides the FSM state encoding, the legal STABLE_CYCLES range, and a
// range-check helper used for elaboration-time parameter checking.
package din_debounce_pkg;

   // Debounce FSM states: two settled levels, each with its candidate-check state.
   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      CHK_HI  = 2'd1,
      IDLE_HI = 2'd2,
      CHK_LO  = 2'd3
   } state_e;

   localparam int unsigned STABLE_MIN = 2;
   localparam int unsigned STABLE_MAX = 255;

   // True when a requested stability window is within the supported range.
   function automatic logic stable_ok(input int unsigned n);
      return (n >= STABLE_MIN) && (n <= STABLE_MAX);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
// Only built when DIN_DEBOUNCE_EVT_CNT_EN is defined; the debouncer is its sole user.
// Ports:
//   clk    in  1  clock, posedge
//   rst_n  in  1  asynchronous active-low reset, count -> 0
//   inc    in  1  increment request (ignored at all-ones)
//   clr    in  1  synchronous clear, wins over inc
//   cnt    out W  registered count value
`ifdef DIN_DEBOUNCE_EVT_CNT_EN
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear first, then increment unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule
`endif

// File: rtl/din_debounce_edge.sv
// Input debouncer with edge strobes. Accepts a new level only after
// STABLE_CYCLES consecutive equal samples, then emits a one-cycle rise/fall
// strobe alongside the clean registered level.
// Optional accepted-edge counter: define DIN_DEBOUNCE_EVT_CNT_EN to build it;
// without it outEvtCnt is tied to 0 and inClr is ignored.
// Ports:
//   inClk      in  1      clock, posedge
//   inRstN     in  1      asynchronous active-low reset
//   inD        in  1      clock-aligned data bit from the sampling stage
//   inClr      in  1      synchronous clear of outEvtCnt
//   outLevel   out 1      debounced level (registered)
//   outRise    out 1      one-cycle strobe on accepted 0->1
//   outFall    out 1      one-cycle strobe on accepted 1->0
//   outBusy    out 1      candidate change under test (registered)
//   outEvtCnt  out EVT_W  saturating accepted-edge count
module din_debounce_edge
   import din_debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned EVT_W         = 8
) (
   input  logic             inClk,
   input  logic             inRstN,
   input  logic             inD,
   input  logic             inClr,
   output logic             outLevel,
   output logic             outRise,
   output logic             outFall,
   output logic             outBusy,
   output logic [EVT_W-1:0] outEvtCnt
);

   // Counter value at which the last required sample is being taken.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   // Reject unsupported configurations at elaboration.
   if (!stable_ok(STABLE_CYCLES) || ((STABLE_CYCLES - 1) >= (64'd1 << CNT_W))) begin : g_param_err
      $error("din_debounce_edge: STABLE_CYCLES out of range or CNT_W too narrow");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             level_q, level_d;
   logic             rise_q,  rise_d;
   logic             fall_q,  fall_d;
   logic             busy_q,  busy_d;

   // Next-state, counter and strobe logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      case (state_q)
         IDLE_LO: begin
            if (inD) begin
               state_d = CHK_HI;
               cnt_d   = CNT_W'(1);
            end
         end
         CHK_HI: begin
            if (!inD) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         IDLE_HI: begin
            if (!inD) begin
               state_d = CHK_LO;
               cnt_d   = CNT_W'(1);
            end
         end
         CHK_LO: begin
            if (inD) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE_LO;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase

      // Busy reflects the state being entered so it registers alongside it.
      busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
   end

   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         state_q <= IDLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   assign outLevel = level_q;
   assign outRise  = rise_q;
   assign outFall  = fall_q;
   assign outBusy  = busy_q;

`ifdef DIN_DEBOUNCE_EVT_CNT_EN
   // Count updates on the same edge that registers the strobe.
   sat_counter #(
      .W (EVT_W)
   ) u_evt_cnt (
      .clk   (inClk),
      .rst_n (inRstN),
      .inc   (rise_d | fall_d),
      .clr   (inClr),
      .cnt   (outEvtCnt)
   );
`else
   logic unused_clr;
   assign unused_clr = inClr;
   assign outEvtCnt  = '0;
`endif

endmodule

// File: tb/tb_din_debounce_edge.sv
// Randomized scoreboard bench for din_debounce_edge (STABLE_CYCLES=4, 40 ns clock).
// Two instances share stimulus: an 8-bit and a 2-bit event counter build.
module tb_din_debounce_edge;
   import din_debounce_pkg::*;

   localparam int STABLE = 4;
`ifdef DIN_DEBOUNCE_EVT_CNT_EN
   localparam bit EVT_ON = 1'b1;
`else
   localparam bit EVT_ON = 1'b0;
`endif

   typedef struct {
      int lvl;
      int rise;
      int fall;
      int busy;
      int evt;
      int evt_s;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_d;
   logic       in_clr;
   logic       level, rise, fall, busy;
   logic [7:0] evt;
   logic       level_s, rise_s, fall_s, busy_s;
   logic [1:0] evt_s;

   int n_total = 0;
   int n_bad   = 0;

   exp_t q[$];
   int   m_run = 0, m_lvl = 0, m_evt = 0, m_evt_s = 0;

   always #20 clk = ~clk;

   din_debounce_edge #(.STABLE_CYCLES(4), .CNT_W(8), .EVT_W(8)) dut (
      .inClk(clk), .inRstN(rst_n), .inD(in_d), .inClr(in_clr),
      .outLevel(level), .outRise(rise), .outFall(fall), .outBusy(busy),
      .outEvtCnt(evt)
   );

   din_debounce_edge #(.STABLE_CYCLES(4), .CNT_W(8), .EVT_W(2)) dut_s (
      .inClk(clk), .inRstN(rst_n), .inD(in_d), .inClr(in_clr),
      .outLevel(level_s), .outRise(rise_s), .outFall(fall_s), .outBusy(busy_s),
      .outEvtCnt(evt_s)
   );

   function automatic void chk(input string name, input int act, input int req);
      n_total++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endfunction

   // Reference model: a level flips once STABLE consecutive samples disagree with it.
   always @(posedge clk) begin
      exp_t e;
      int   d, run, lvl, r, f, ev, evs;
      if (!rst_n) begin
         e = '{default: 0};
      end else begin
         d = int'(in_d);
         run = m_run; lvl = m_lvl; r = 0; f = 0;
         if (d != lvl) begin
            run++;
            if (run == STABLE) begin
               lvl = d;
               run = 0;
               if (d == 1) r = 1; else f = 1;
            end
         end else begin
            run = 0;
         end
         ev = m_evt; evs = m_evt_s;
         if (EVT_ON) begin
            if (in_clr) begin
               ev = 0; evs = 0;
            end else if ((r + f) != 0) begin
               if (ev < 255) ev++;
               if (evs < 3) evs++;
            end
         end
         m_run <= run; m_lvl <= lvl; m_evt <= ev; m_evt_s <= evs;
         e = '{lvl, r, f, int'(run != 0), ev, evs};
      end
      q.push_back(e);
   end

   // Asynchronous reset: model clears and any not-yet-shown expectation becomes reset state.
   always @(negedge rst_n) begin
      m_run <= 0; m_lvl <= 0; m_evt <= 0; m_evt_s <= 0;
      if (q.size() > 0) begin
         void'(q.pop_back());
         q.push_back('{default: 0});
      end
   end

   // Monitor: one expected entry per clock, compared away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() == 0) begin
         n_total++;
         n_bad++;
         $display("FAIL scoreboard_empty actual=0 required=1 t=%0t", $time);
      end else begin
         e = q.pop_front();
         chk("level",   int'(level),   e.lvl);
         chk("rise",    int'(rise),    e.rise);
         chk("fall",    int'(fall),    e.fall);
         chk("busy",    int'(busy),    e.busy);
         chk("evt",     int'(evt),     e.evt);
         chk("level_s", int'(level_s), e.lvl);
         chk("rise_s",  int'(rise_s),  e.rise);
         chk("fall_s",  int'(fall_s),  e.fall);
         chk("busy_s",  int'(busy_s),  e.busy);
         chk("evt_s",   int'(evt_s),   e.evt_s);
         chk("rise_and_fall", int'(rise & fall), 0);
      end
   end

   // Present inputs at a falling edge and return at the next one.
   task automatic drive(input logic d, input logic clr);
      in_d   = d;
      in_clr = clr;
      @(negedge clk);
   endtask

   initial begin
      int v, len;
      rst_n  = 1'b0;
      in_d   = 1'b1;
      in_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_level", int'(level), 0);
      chk("rst_busy",  int'(busy),  0);
      chk("rst_evt",   int'(evt),   0);

      // Release with input already high: reported as a rise after 4 samples.
      rst_n = 1'b1;
      repeat (3) drive(1'b1, 1'b0);
      chk("pre_rise_level", int'(level), 0);
      chk("pre_rise_busy",  int'(busy),  1);
      drive(1'b1, 1'b0);
      chk("rel_rise",  int'(rise),  1);
      chk("rel_level", int'(level), 1);
      chk("rel_evt",   int'(evt),   EVT_ON ? 1 : 0);
      drive(1'b1, 1'b0);
      chk("rel_rise_off", int'(rise), 0);

      // Clean fall.
      repeat (4) drive(1'b0, 1'b0);
      chk("fall_strobe", int'(fall),  1);
      chk("fall_level",  int'(level), 0);
      chk("fall_evt",    int'(evt),   EVT_ON ? 2 : 0);
      drive(1'b0, 1'b0);
      chk("fall_off", int'(fall), 0);

      // Three-sample glitch is rejected.
      repeat (3) drive(1'b1, 1'b0);
      chk("glitch_busy", int'(busy), 1);
      drive(1'b0, 1'b0);
      chk("glitch_busy_off", int'(busy),  0);
      chk("glitch_level",    int'(level), 0);
      drive(1'b0, 1'b0);

      // Chatter every 6 ns, offset so toggles never land on a rising edge.
      #3;
      repeat (27) begin
         in_d = ~in_d;
         #6;
      end
      @(negedge clk);
      repeat (6) drive(1'b0, 1'b0);

      // Random runs of random length with occasional clears.
      repeat (60) begin
         v   = int'($urandom_range(0, 1));
         len = int'($urandom_range(1, 7));
         repeat (len) drive(v[0], ($urandom_range(0, 7) == 0));
      end

      // Saturation: settle low, clear, then five clean edges.
      repeat (6) drive(1'b0, 1'b0);
      drive(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         repeat (5) drive(((i % 2) == 0), 1'b0);
      end
      chk("sat_evt_s", int'(evt_s), EVT_ON ? 3 : 0);
      chk("sat_evt",   int'(evt),   EVT_ON ? 5 : 0);

      // Clear on the same edge as an accepted fall: clear wins.
      repeat (3) drive(1'b0, 1'b0);
      drive(1'b0, 1'b1);
      chk("clr_fall",  int'(fall),  1);
      chk("clr_evt",   int'(evt),   0);
      chk("clr_evt_s", int'(evt_s), 0);
      drive(1'b0, 1'b0);

      // Reset in the middle of a high check (count 2) aborts it.
      repeat (2) drive(1'b1, 1'b0);
      #5 rst_n = 1'b0;
      #1;
      chk("midrst_busy",  int'(busy),  0);
      chk("midrst_level", int'(level), 0);
      chk("midrst_rise",  int'(rise),  0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) drive(1'b1, 1'b0);
      chk("midrst_no_early_rise", int'(rise), 0);
      drive(1'b1, 1'b0);
      chk("midrst_rise_after", int'(rise), 1);
      repeat (4) drive(1'b1, 1'b0);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
